// File: rtl/rv_fetch_pkg.sv
// Shared types for the instruction fetch path: word width and the fetch queue entry.
package rv_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response and decode-side handshake bundle for ifetch_unit.
interface ifetch_unit_if;
  import rv_fetch_pkg::*;

  logic            imem_req_valid_o;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_req_ready_i;
  logic            imem_rsp_valid_i;
  logic [XLEN-1:0] imem_rsp_data_i;
  logic            instr_valid_o;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_ready_i;

  modport master (
    output imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, instr_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetch entries: allocated at request, filled at response, popped by decode.
// Flush clears every entry and pointer; the caller guarantees alloc only when not full.
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [CW-1:0]   count_o,
  output logic [CW-1:0]   unfilled_o
);
  fetch_entry_t  ent_q [DEPTH];
  logic [PW-1:0] alloc_q, fill_q, head_q;
  logic [CW-1:0] count_q, count_d, nfill_q, nfill_d;

  assign count_d = count_q + CW'(alloc_i) - CW'(pop_i);
  assign nfill_d = nfill_q + CW'(fill_i) - CW'(pop_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
      nfill_q <= '0;
    end else begin
      // alloc, fill and pop always touch distinct entries, so all three may land together
      if (alloc_i) begin
        ent_q[alloc_q] <= '{pc: alloc_pc_i, data: '0, filled: 1'b0};
        alloc_q        <= alloc_q + 1'b1;
      end
      if (fill_i) begin
        ent_q[fill_q].data   <= fill_data_i;
        ent_q[fill_q].filled <= 1'b1;
        fill_q               <= fill_q + 1'b1;
      end
      if (pop_i) begin
        ent_q[head_q].filled <= 1'b0;
        head_q               <= head_q + 1'b1;
      end
      count_q <= count_d;
      nfill_q <= nfill_d;
    end
  end

  assign head_o     = ent_q[head_q];
  assign count_o    = count_q;
  assign unfilled_o = count_q - nfill_q;
endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: gates memory requests on queue space, advances the PC per accepted request,
// and discards responses belonging to fetches flushed by a redirect.
module ifetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  input  logic            redirect_i,
  ifetch_unit_if.master   bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = CW + 3;

  fetch_entry_t  head;
  logic [CW-1:0] count, unfilled;
  logic          req_hs, fill, pop, rsp_live;
  logic [DW-1:0] drop_q, drop_d;

  assign bus.imem_req_valid_o = !redirect_i && !rst_i && (count < CW'(DEPTH));
  assign bus.imem_req_addr_o  = {pc_i[XLEN-1:2], 2'b00};
  assign req_hs               = bus.imem_req_valid_o && bus.imem_req_ready_i;
  assign pc_en_o              = req_hs;

  assign rsp_live = bus.imem_rsp_valid_i && ((drop_q != '0) || (unfilled != '0));
  assign fill     = bus.imem_rsp_valid_i && (drop_q == '0) && (unfilled != '0) && !redirect_i;
  assign pop      = head.filled && bus.instr_ready_i;

  assign bus.instr_valid_o = head.filled;
  assign bus.instr_o       = head.data;
  assign bus.instr_pc_o    = head.pc;

  // A redirect while still draining an earlier flush keeps those pending drops too;
  // a response in the redirect cycle itself is counted against the new total.
  always_comb begin
    drop_d = drop_q;
    if (redirect_i) begin
      drop_d = drop_q + DW'(unfilled) - DW'(rsp_live);
    end else if (bus.imem_rsp_valid_i && (drop_q != '0)) begin
      drop_d = drop_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .alloc_i     (req_hs),
    .alloc_pc_i  (pc_i),
    .fill_i      (fill),
    .fill_data_i (bus.imem_rsp_data_i),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .unfilled_o  (unfilled)
  );
endmodule
